btn_debounce_pulse: RTL and testbench
=====================================

Name: btn_debounce_pulse

Overview:
- Front-end conditioning stage for board push-buttons and slide switches.
- Synchronises the asynchronous pin into the clk domain and debounces it with a stable-count FSM.
- Emits a clean level plus single-cycle rise/fall pulses.
- Outputs drive the d / enable inputs of downstream registered stages (flip-flops, counters, FSMs) directly, with no further glitch filtering.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a change (10 ms at 100 MHz); legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous, active-low reset.
- btn_in  input  1  raw asynchronous button/switch pin.
- btn_level  output  1  debounced level, registered.
- btn_rise  output  1  one-cycle pulse when btn_level goes 0->1.
- btn_fall  output  1  one-cycle pulse when btn_level goes 1->0.
- busy  output  1  high while FSM is in a WAIT state (candidate change being qualified).

Behaviour:
- Reset: any posedge with rstn=0 clears all of the following, overriding everything else:
  - sync chain = 0, cnt = 0, state = IDLE_LO.
  - btn_level = 0, btn_rise = 0, btn_fall = 0, busy = 0.
- Synchroniser: btn_in shifts through SYNC_STAGES flops; s = last stage. The FSM first sees a pin change at edge SYNC_STAGES (edge 0 = first edge after the change).
- States: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- IDLE_LO:
  - s=1: go WAIT_HI, cnt<=1.
  - else: stay, cnt<=0.
- WAIT_HI:
  - s=0: go IDLE_LO, cnt<=0. Bounce rejected, no pulse.
  - s=1 and cnt==DEBOUNCE_CYCLES-1: go IDLE_HI, btn_level<=1, btn_rise<=1, cnt<=0.
  - s=1 otherwise: cnt<=cnt+1.
- IDLE_HI / WAIT_LO: mirror image with s=0 qualifying, btn_level<=0 and btn_fall<=1.
- Latency: a clean pin change updates btn_level at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. The pulse asserts on the same edge and is visible for exactly one cycle.
- btn_rise and btn_fall default to 0 every cycle. They are never both high and never high for two consecutive cycles.
- busy = (state==WAIT_HI || state==WAIT_LO), registered with the state.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. A bounce on the final count cycle still rejects the change.
- A pulse of s shorter than DEBOUNCE_CYCLES samples produces no output change regardless of repetition.
- Reset mid-WAIT: qualification is discarded and no pulse is issued. If the pin is held high through reset, a full debounce and a btn_rise occur after release of rstn.
- No combinational path from btn_in to any output.

Decomposition:
- Package btn_pkg:
  - btn_state_t enum (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO).
  - Default DEBOUNCE_CYCLES constant for 100 MHz.
  - Simulation constant DEBOUNCE_SIM = 4.
- Sub-module sync_chain (parameter STAGES; ports clk, rstn, d, q), a synchronous-reset flop shift register reusable by other pin inputs.
- Debounce FSM and counter live in btn_debounce_pulse.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4: hold btn_in=0 with rstn=0 for 3 edges, then release -> all outputs 0, busy 0.
- Clean press: btn_in 0->1 before edge 0 -> busy=1 after edge 2; btn_level=1 and btn_rise=1 after edge 5; btn_rise=0 after edge 6.
- Bounce: btn_in high for 3 cycles, low for 1, repeated 5 times -> btn_level stays 0, no btn_rise, busy toggles.
- Clean release from IDLE_HI -> btn_fall single pulse at edge 5 after change; btn_level=0; btn_rise stays 0.
- Reset during WAIT_HI: assert rstn=0 at edge 3 of a press while holding btn_in=1 -> outputs 0. After release, btn_rise occurs 5 edges after the first edge with rstn=1.
- Random-glitch soak (10k cycles, glitch widths 1..3) -> zero pulses; assertion checks: rise/fall never both high, never consecutive, cnt ≤ 3.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for push-button / switch conditioning.
package btn_pkg;

  typedef enum logic [1:0] {
    IdleLo,
    WaitHi,
    IdleHi,
    WaitLo
  } btn_state_t;

  // 10 ms of stable input at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 1000000;

  // Short qualification window so simulations stay fast.
  localparam int unsigned DEBOUNCE_SIM = 4;

endpackage

// File: rtl/sync_chain.sv
// Synchronous-reset flop shift register for bringing an asynchronous pin into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : gen_bad_stages
    $error("sync_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button/switch front end: synchroniser, stable-count debounce FSM, level and edge pulses.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync
    $error("btn_debounce_pulse: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : gen_bad_debounce
    $error("btn_debounce_pulse: DEBOUNCE_CYCLES must be at least 2");
  end

  logic s;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (btn_in),
    .q   (s)
  );

  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  // cnt_q holds the number of consecutive candidate samples seen so far in a WAIT state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IdleLo;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IdleLo: begin
          if (s) begin
            state_q <= WaitHi;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        WaitHi: begin
          if (!s) begin
            state_q <= IdleLo;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IdleHi;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IdleHi: begin
          if (!s) begin
            state_q <= WaitLo;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        WaitLo: begin
          if (s) begin
            state_q <= IdleHi;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IdleLo;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed and random-glitch bench for btn_debounce_pulse against a window-based reference model.
module tb_btn_debounce_pulse;
  import btn_pkg::*;

  localparam int unsigned S = 2;
  localparam int unsigned D = DEBOUNCE_SIM;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level, btn_rise, btn_fall, busy;

  btn_debounce_pulse #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rise   = 0;
  int n_fall   = 0;

  // Reference model: pin delayed S edges, level flips once the last D samples all disagree.
  bit pipe[$];
  bit win[$];
  bit m_level, m_rise, m_fall, m_busy;
  logic prev_rise = 1'b0;
  logic prev_fall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    pipe = {};
    repeat (S) pipe.push_back(1'b0);
    win     = {};
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit pin);
    bit s;
    bit all_diff;
    if (!r) begin
      model_reset();
    end else begin
      s = pipe[S-1];
      pipe.push_front(pin);
      void'(pipe.pop_back());
      win.push_back(s);
      if (win.size() > D) void'(win.pop_front());
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (win.size() == D) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
          m_level = !m_level;
          if (m_level) m_rise = 1'b1;
          else m_fall = 1'b1;
        end
      end
      m_busy = (s != m_level);
    end
  endtask

  // One clock edge: inputs are sampled as driven, outputs checked 1 time unit later.
  task automatic step();
    bit r, p;
    r = rstn;
    p = btn_in;
    @(posedge clk);
    model_edge(r, p);
    #1;
    chk("level", btn_level, m_level);
    chk("rise", btn_rise, m_rise);
    chk("fall", btn_fall, m_fall);
    chk("busy", busy, m_busy);
    chk("rise_fall_both", btn_rise & btn_fall, 0);
    chk("rise_consec", btn_rise & prev_rise, 0);
    chk("fall_consec", btn_fall & prev_fall, 0);
    chk("cnt_bound", (int'(dut.cnt_q) <= int'(D - 1)), 1);
    prev_rise = btn_rise;
    prev_fall = btn_fall;
    if (btn_rise === 1'b1) n_rise++;
    if (btn_fall === 1'b1) n_fall++;
  endtask

  // Glitches of 1..3 cycles away from base, separated by random gaps at base.
  task automatic soak(input bit base, input int cycles);
    int done;
    int gap;
    int w;
    done = 0;
    while (done < cycles) begin
      btn_in = base;
      gap = int'($urandom_range(1, 6));
      repeat (gap) step();
      btn_in = !base;
      w = int'($urandom_range(1, 3));
      repeat (w) step();
      done += gap + w;
    end
    btn_in = base;
    repeat (6) step();
  endtask

  initial begin
    int r0, f0, busy_cnt;
    model_reset();

    // Reset
    rstn   = 1'b0;
    btn_in = 1'b0;
    repeat (3) step();
    chk("rst_level", btn_level, 0);
    chk("rst_rise", btn_rise, 0);
    chk("rst_fall", btn_fall, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    repeat (4) step();
    chk("idle_busy", busy, 0);

    // Clean press
    btn_in = 1'b1;
    repeat (3) step();
    chk("press_busy_e2", busy, 1);
    repeat (2) step();
    chk("press_level_e4", btn_level, 0);
    step();
    chk("press_level_e5", btn_level, 1);
    chk("press_rise_e5", btn_rise, 1);
    chk("press_busy_e5", busy, 0);
    step();
    chk("press_rise_e6", btn_rise, 0);
    chk("press_level_e6", btn_level, 1);
    repeat (3) step();

    // Clean release
    r0 = n_rise;
    btn_in = 1'b0;
    repeat (4) step();
    chk("rel_level_e3", btn_level, 1);
    step();
    chk("rel_fall_e4", btn_fall, 0);
    step();
    chk("rel_fall_e5", btn_fall, 1);
    chk("rel_level_e5", btn_level, 0);
    step();
    chk("rel_fall_e6", btn_fall, 0);
    chk("rel_no_rise", n_rise - r0, 0);
    repeat (3) step();

    // Bounce: 3 high, 1 low, five times
    r0 = n_rise;
    busy_cnt = 0;
    repeat (5) begin
      btn_in = 1'b1;
      repeat (3) begin
        step();
        busy_cnt += int'(busy);
      end
      btn_in = 1'b0;
      step();
      busy_cnt += int'(busy);
    end
    repeat (6) begin
      step();
      busy_cnt += int'(busy);
    end
    chk("bounce_no_rise", n_rise - r0, 0);
    chk("bounce_level", btn_level, 0);
    chk("bounce_busy_cycles", busy_cnt, 15);

    // Reset while qualifying a press
    r0 = n_rise;
    btn_in = 1'b1;
    repeat (3) step();
    chk("rstwait_busy", busy, 1);
    rstn = 1'b0;
    step();
    chk("rstwait_busy_clr", busy, 0);
    chk("rstwait_level", btn_level, 0);
    chk("rstwait_rise", btn_rise, 0);
    rstn = 1'b1;
    repeat (5) step();
    chk("rstwait_no_early_rise", n_rise - r0, 0);
    step();
    chk("rstwait_rise_e5", btn_rise, 1);
    chk("rstwait_level_e5", btn_level, 1);
    btn_in = 1'b0;
    repeat (10) step();
    chk("rstwait_released", btn_level, 0);

    // Random glitch soak around a low level, then around a high level
    r0 = n_rise;
    f0 = n_fall;
    soak(1'b0, 5000);
    chk("soak_lo_rise", n_rise - r0, 0);
    chk("soak_lo_fall", n_fall - f0, 0);
    chk("soak_lo_level", btn_level, 0);
    btn_in = 1'b1;
    repeat (8) step();
    chk("soak_mid_level", btn_level, 1);
    r0 = n_rise;
    f0 = n_fall;
    soak(1'b1, 5000);
    chk("soak_hi_rise", n_rise - r0, 0);
    chk("soak_hi_fall", n_fall - f0, 0);
    chk("soak_hi_level", btn_level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
